// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ requesters.
// Captures the winning frame, drives send/din, and reports completion per requester.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FRAME_WD = 8,
  localparam int ID_WD = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*FRAME_WD-1:0]  req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         tx_send,
  output logic [FRAME_WD-1:0]          tx_din,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  output logic                         arb_busy,
  output logic [ID_WD-1:0]             cur_id
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE
  } state_t;

  state_t state;
  logic [ID_WD-1:0] last;

  logic [ID_WD-1:0]    win_id;
  logic                win_found;
  logic [FRAME_WD-1:0] win_data;

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [ID_WD-1:0] id);
    logic [NUM_REQ-1:0] vec;
    vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_WD'(i) == id) vec[i] = 1'b1;
    end
    return vec;
  endfunction

  // Search starts just after the last winner and wraps, so each requester gets a turn.
  always_comb begin
    int idx;
    idx       = 0;
    win_id    = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_WD'(idx);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_WD'(i) == win_id) win_data = req_data[i*FRAME_WD +: FRAME_WD];
    end
  end

  // tx_din is only loaded at a grant, because uart_tx samples din well after send.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      done     <= '0;
      tx_send  <= 1'b0;
      tx_din   <= '0;
      arb_busy <= 1'b0;
      cur_id   <= '0;
      last     <= ID_WD'(NUM_REQ - 1);
    end else begin
      grant <= '0;
      done  <= '0;
      case (state)
        IDLE: begin
          tx_send  <= 1'b0;
          arb_busy <= 1'b0;
          if (en && win_found) begin
            grant    <= to_onehot(win_id);
            tx_din   <= win_data;
            cur_id   <= win_id;
            tx_send  <= 1'b1;
            arb_busy <= 1'b1;
            last     <= win_id;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_busy) begin
            tx_send <= 1'b0;
            state   <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            done  <= to_onehot(cur_id);
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed stimulus pushes expected grants/dones,
// a negedge monitor pops and compares whenever the arbiter pulses an output.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int FRAME_WD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        tx_send;
  logic [7:0]  tx_din;
  logic        arb_busy;
  logic [1:0]  cur_id;

  int checks = 0;
  int failures = 0;
  int grant_seen = 0;

  logic [3:0] exp_grant_q[$];
  logic [7:0] exp_din_q[$];
  logic [3:0] exp_done_q[$];
  logic [7:0] exp_ser_q[$];

  logic [3:0] hold_mask = '0;
  bit ser_on = 1'b0;
  int ser_state = 0;
  int ser_cnt = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .FRAME_WD(FRAME_WD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .tx_send(tx_send), .tx_din(tx_din),
    .tx_busy(tx_busy), .tx_done(tx_done), .arb_busy(arb_busy), .cur_id(cur_id)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  // Monitor: every grant/done pulse is matched against the scoreboard in issue order.
  always @(negedge clk) begin
    if (grant != 4'd0 || done != 4'd0)
      check_output("grant_done_exclusive", 32'(grant != 4'd0 && done != 4'd0), 32'd0);
    if (grant != 4'd0) begin
      grant_seen++;
      if (exp_grant_q.size() == 0) check_output("grant_unexpected", 32'(grant), 32'd0);
      else begin
        check_output("grant_value", 32'(grant), 32'(exp_grant_q.pop_front()));
        check_output("grant_din", 32'(tx_din), 32'(exp_din_q.pop_front()));
      end
    end
    if (done != 4'd0) begin
      if (exp_done_q.size() == 0) check_output("done_unexpected", 32'(done), 32'd0);
      else check_output("done_value", 32'(done), 32'(exp_done_q.pop_front()));
    end
  end

  // One clock of bench activity: requesters drop granted bits, serializer model advances.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i] && !hold_mask[i]) req[i] = 1'b0;
    if (ser_on) begin
      if (ser_state == 0) begin
        tx_done = 1'b0;
        if (tx_send) begin
          tx_busy = 1'b1;
          ser_cnt = 6;
          ser_state = 1;
        end
      end else begin
        ser_cnt--;
        if (ser_cnt == 3) begin
          if (exp_ser_q.size() == 0) check_output("ser_frame_expected", 32'(exp_ser_q.size()), 32'd1);
          else check_output("ser_din", 32'(tx_din), 32'(exp_ser_q.pop_front()));
        end
        if (ser_cnt == 0) begin
          tx_busy = 1'b0;
          tx_done = 1'b1;
          ser_state = 0;
        end
      end
    end
  endtask

  task automatic expect_frame(input logic [3:0] g, input logic [7:0] d, input bit ser);
    exp_grant_q.push_back(g);
    exp_din_q.push_back(d);
    exp_done_q.push_back(g);
    if (ser) exp_ser_q.push_back(d);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_grant_q.size() != 0 || exp_done_q.size() != 0 || exp_ser_q.size() != 0 || arb_busy)
           && n < budget) begin
      tick();
      n++;
    end
    check_output({name, "_within_budget"}, 32'(n >= budget), 32'd0);
    check_output({name, "_queues_empty"},
                 32'(exp_grant_q.size() + exp_done_q.size() + exp_ser_q.size()), 32'd0);
    check_output({name, "_arb_idle"}, 32'(arb_busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    en = 1'b0;
    ser_on = 1'b0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    ser_state = 0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, "_grant"}, 32'(grant), 32'd0);
    check_output({name, "_done"}, 32'(done), 32'd0);
    check_output({name, "_tx_send"}, 32'(tx_send), 32'd0);
    check_output({name, "_tx_din"}, 32'(tx_din), 32'd0);
    check_output({name, "_arb_busy"}, 32'(arb_busy), 32'd0);
    check_output({name, "_cur_id"}, 32'(cur_id), 32'd0);
  endtask

  task automatic apply_stimulus();
    int n;
    int base;

    // Reset values
    repeat (2) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    en = 1'b1;
    tick();

    // Single request from requester 2
    ser_on = 1'b1;
    req_data[23:16] = 8'hA5;
    expect_frame(4'b0100, 8'hA5, 1'b1);
    req = 4'b0100;
    tick();
    check_output("t1_grant_latency", 32'(grant), 32'h4);
    check_output("t1_tx_send", 32'(tx_send), 32'd1);
    check_output("t1_arb_busy", 32'(arb_busy), 32'd1);
    check_output("t1_cur_id", 32'(cur_id), 32'd2);
    n = 0;
    while (done == 4'd0 && n < 50) begin
      tick();
      n++;
    end
    check_output("t1_done", 32'(done), 32'h4);
    check_output("t1_busy_in_done_cycle", 32'(arb_busy), 32'd1);
    tick();
    check_output("t1_busy_after_done", 32'(arb_busy), 32'd0);
    check_output("t1_done_single", 32'(done), 32'd0);
    wait_drain("t1", 50);

    // All four requesting from a fresh pointer
    do_reset();
    en = 1'b1;
    ser_on = 1'b1;
    req_data = 32'h13121110;
    expect_frame(4'b0001, 8'h10, 1'b1);
    expect_frame(4'b0010, 8'h11, 1'b1);
    expect_frame(4'b0100, 8'h12, 1'b1);
    expect_frame(4'b1000, 8'h13, 1'b1);
    req = 4'b1111;
    wait_drain("t2", 300);

    // Fairness between two permanently requesting sources
    req_data = 32'h00220020;
    for (int i = 0; i < 8; i++)
      expect_frame((i % 2 == 0) ? 4'b0001 : 4'b0100, (i % 2 == 0) ? 8'h20 : 8'h22, 1'b1);
    hold_mask = 4'b0101;
    req = 4'b0101;
    base = grant_seen;
    n = 0;
    while (grant_seen - base < 8 && n < 400) begin
      tick();
      n++;
    end
    check_output("t3_eight_grants", 32'(grant_seen - base), 32'd8);
    req = '0;
    hold_mask = '0;
    wait_drain("t3", 100);

    // en dropped during WAIT_DONE with requester 1 pending
    req_data = 32'h00004140;
    expect_frame(4'b0001, 8'h40, 1'b1);
    req = 4'b0001;
    n = 0;
    while (!tx_busy && n < 20) begin
      tick();
      n++;
    end
    check_output("t4_serializer_busy", 32'(tx_busy), 32'd1);
    en = 1'b0;
    req[1] = 1'b1;
    wait_drain("t4a", 50);
    base = grant_seen;
    repeat (10) tick();
    check_output("t4_no_grant_while_disabled", 32'(grant_seen - base), 32'd0);
    expect_frame(4'b0010, 8'h41, 1'b1);
    en = 1'b1;
    tick();
    check_output("t4_grant_after_enable", 32'(grant), 32'h2);
    wait_drain("t4b", 50);

    // Idle pulses, spurious tx_done in SEND, tx_din stability
    ser_on = 1'b0;
    tx_done = 1'b1;
    tx_busy = 1'b1;
    tick();
    check_output("t5_idle_pulse_done", 32'(done), 32'd0);
    check_output("t5_idle_pulse_busy", 32'(arb_busy), 32'd0);
    tx_done = 1'b0;
    tx_busy = 1'b0;
    req_data[23:16] = 8'h3C;
    expect_frame(4'b0100, 8'h3C, 1'b0);
    req = 4'b0100;
    tick();
    req_data[23:16] = 8'hFF;
    tx_done = 1'b1;
    tick();
    check_output("t5_spurious_done_ignored", 32'(done), 32'd0);
    check_output("t5_send_held", 32'(tx_send), 32'd1);
    tx_done = 1'b0;
    tick();
    check_output("t5_din_after_data_change", 32'(tx_din), 32'h3C);
    tx_busy = 1'b1;
    tick();
    check_output("t5_send_dropped", 32'(tx_send), 32'd0);
    tx_busy = 1'b0;
    repeat (3) tick();
    check_output("t5_din_stable", 32'(tx_din), 32'h3C);
    tx_done = 1'b1;
    tick();
    check_output("t5_done", 32'(done), 32'h4);
    tx_done = 1'b0;
    tick();
    check_output("t5_din_after_done", 32'(tx_din), 32'h3C);
    ser_on = 1'b1;
    expect_frame(4'b0100, 8'hFF, 1'b1);
    req = 4'b0100;
    wait_drain("t5", 50);

    // Reset in the middle of a frame abandons it without a done pulse
    ser_on = 1'b0;
    req_data[15:8] = 8'h61;
    exp_grant_q.push_back(4'b0010);
    exp_din_q.push_back(8'h61);
    req = 4'b0010;
    tick();
    check_output("t6_cur_id", 32'(cur_id), 32'd1);
    tx_busy = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_async_reset");
    tx_busy = 1'b0;
    req = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    ser_on = 1'b1;
    req_data = 32'hAA000055;
    expect_frame(4'b0001, 8'h55, 1'b1);
    expect_frame(4'b1000, 8'hAA, 1'b1);
    req = 4'b1001;
    wait_drain("t6", 100);
  endtask

  initial begin
    apply_stimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
